// File: rtl/core_config.sv
// Core-wide configuration constants shared by the memory-stage atomic logic.
package core_config;

    localparam int DATA_WIDTH = 32;
    localparam int GPR_NUM    = 32;
    localparam int GPR_AW     = $clog2(GPR_NUM);

endpackage

// File: rtl/core_types.sv
// Types shared by the LL/SC sequencer: FSM state encoding and the latched atomic request.
package core_types;

    import core_config::*;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        RESP  = 3'd4
    } llsc_state_e;

    // Field widths follow core_config; the sequencer's defaults match them.
    typedef struct packed {
        logic                  is_sc;
        logic [DATA_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [GPR_AW-1:0]     rd;
    } atomic_req_t;

    localparam logic [3:0] WSTRB_WORD = 4'b1111;

    function automatic logic word_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/llbit_reg.sv
// LLbit storage: set by a completed LL, cleared by SC completion, ERTN (KLO=0) or WCLLB; clear wins.
module llbit_reg (
    input  logic clk,
    input  logic rst,
    input  logic ll_set_i,
    input  logic sc_clr_i,
    input  logic ertn_i,
    input  logic klo_i,
    input  logic wcllb_i,
    output logic llbit_o
);

    logic llbit_q;
    logic llbit_d;
    logic clr;

    assign clr = sc_clr_i || (ertn_i && !klo_i) || wcllb_i;

    always_comb begin
        llbit_d = llbit_q;
        if (clr) begin
            llbit_d = 1'b0;
        end else if (ll_set_i) begin
            llbit_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            llbit_q <= 1'b0;
        end else begin
            llbit_q <= llbit_d;
        end
    end

    assign llbit_o = llbit_q;

endmodule

// File: rtl/llsc_sequencer.sv
// LL.W / SC.W sequencer between the MEM stage, the data cache and writeback.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
module llsc_sequencer
    import core_types::*;
#(
    parameter int DATA_WIDTH = core_config::DATA_WIDTH,
    parameter int GPR_NUM    = core_config::GPR_NUM
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_is_sc_i,
    input  logic [DATA_WIDTH-1:0]      req_addr_i,
    input  logic [DATA_WIDTH-1:0]      req_wdata_i,
    input  logic [$clog2(GPR_NUM)-1:0] req_rd_i,

    output logic                       dc_req_valid_o,
    input  logic                       dc_req_ready_i,
    output logic                       dc_we_o,
    output logic [DATA_WIDTH-1:0]      dc_addr_o,
    output logic [DATA_WIDTH-1:0]      dc_wdata_o,
    output logic [3:0]                 dc_wstrb_o,
    input  logic                       dc_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0]      dc_rdata_i,

    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    output logic [DATA_WIDTH-1:0]      res_data_o,
    output logic [$clog2(GPR_NUM)-1:0] res_rd_o,
    output logic                       res_ale_o,

    input  logic                       flush_i,
    input  logic                       ertn_i,
    input  logic                       llbctl_klo_i,
    input  logic                       llbctl_wcllb_i,
    output logic                       llbit_o
);

    localparam logic [DATA_WIDTH-1:0] SC_SUCCESS = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    llsc_state_e           state_q, state_d;
    atomic_req_t           req_q, req_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic                  res_ale_q, res_ale_d;

    logic llbit;
    logic ll_set;
    logic sc_clr;
    logic req_fire;
    logic in_issue;
    logic in_resp;

    assign req_ready_o = (state_q == IDLE) && !flush_i;
    assign req_fire    = req_valid_i && req_ready_o;
    assign in_issue    = (state_q == ISSUE);
    assign in_resp     = (state_q == RESP);

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        res_data_d = res_data_q;
        res_ale_d  = res_ale_q;
        ll_set     = 1'b0;
        sc_clr     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_fire) begin
                    req_d.is_sc = req_is_sc_i;
                    req_d.addr  = req_addr_i;
                    req_d.wdata = req_wdata_i;
                    req_d.rd    = req_rd_i;
                    res_data_d  = '0;
                    res_ale_d   = 1'b0;
                    if (word_misaligned(req_addr_i[1:0])) begin
                        res_ale_d = 1'b1;
                        state_d   = RESP;
                    end else if (req_is_sc_i && !llbit) begin
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end

            ISSUE: begin
                // A handshake in the flush cycle still owes us a response.
                if (flush_i) begin
                    state_d = dc_req_ready_i ? DRAIN : IDLE;
                end else if (dc_req_ready_i) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (dc_rsp_valid_i) begin
                    if (req_q.is_sc) begin
                        sc_clr     = 1'b1;
                        res_data_d = SC_SUCCESS;
                    end else begin
                        ll_set     = !flush_i;
                        res_data_d = dc_rdata_i;
                    end
                    state_d = flush_i ? IDLE : RESP;
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                // The store already happened in the cache, so its LLbit clear still applies.
                if (dc_rsp_valid_i) begin
                    sc_clr  = req_q.is_sc;
                    state_d = IDLE;
                end
            end

            RESP: begin
                if (flush_i || res_ready_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= '0;
            res_data_q <= '0;
            res_ale_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            res_data_q <= res_data_d;
            res_ale_q  <= res_ale_d;
        end
    end

    llbit_reg u_llbit (
        .clk      (clk),
        .rst      (rst),
        .ll_set_i (ll_set),
        .sc_clr_i (sc_clr),
        .ertn_i   (ertn_i),
        .klo_i    (llbctl_klo_i),
        .wcllb_i  (llbctl_wcllb_i),
        .llbit_o  (llbit)
    );

    assign llbit_o = llbit;

    assign dc_req_valid_o = in_issue;
    assign dc_we_o        = in_issue && req_q.is_sc;
    assign dc_addr_o      = in_issue ? req_q.addr : '0;
    assign dc_wdata_o     = (in_issue && req_q.is_sc) ? req_q.wdata : '0;
    assign dc_wstrb_o     = (in_issue && req_q.is_sc) ? WSTRB_WORD : 4'b0000;

    assign res_valid_o = in_resp;
    assign res_data_o  = in_resp ? res_data_q : '0;
    assign res_rd_o    = in_resp ? req_q.rd : '0;
    assign res_ale_o   = in_resp && res_ale_q;

endmodule

// File: tb/tb_llsc_sequencer.sv
// Scoreboard bench for llsc_sequencer: directed corner cases plus randomized LL/SC traffic.
module tb_llsc_sequencer;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_is_sc_i = 1'b0;
    logic [DW-1:0] req_addr_i = '0;
    logic [DW-1:0] req_wdata_i = '0;
    logic [RW-1:0] req_rd_i = '0;
    logic          dc_req_valid_o;
    logic          dc_req_ready_i = 1'b0;
    logic          dc_we_o;
    logic [DW-1:0] dc_addr_o;
    logic [DW-1:0] dc_wdata_o;
    logic [3:0]    dc_wstrb_o;
    logic          dc_rsp_valid_i = 1'b0;
    logic [DW-1:0] dc_rdata_i = '0;
    logic          res_valid_o;
    logic          res_ready_i = 1'b1;
    logic [DW-1:0] res_data_o;
    logic [RW-1:0] res_rd_o;
    logic          res_ale_o;
    logic          flush_i = 1'b0;
    logic          ertn_i = 1'b0;
    logic          llbctl_klo_i = 1'b0;
    logic          llbctl_wcllb_i = 1'b0;
    logic          llbit_o;

    llsc_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_is_sc_i    (req_is_sc_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .req_rd_i       (req_rd_i),
        .dc_req_valid_o (dc_req_valid_o),
        .dc_req_ready_i (dc_req_ready_i),
        .dc_we_o        (dc_we_o),
        .dc_addr_o      (dc_addr_o),
        .dc_wdata_o     (dc_wdata_o),
        .dc_wstrb_o     (dc_wstrb_o),
        .dc_rsp_valid_i (dc_rsp_valid_i),
        .dc_rdata_i     (dc_rdata_i),
        .res_valid_o    (res_valid_o),
        .res_ready_i    (res_ready_i),
        .res_data_o     (res_data_o),
        .res_rd_o       (res_rd_o),
        .res_ale_o      (res_ale_o),
        .flush_i        (flush_i),
        .ertn_i         (ertn_i),
        .llbctl_klo_i   (llbctl_klo_i),
        .llbctl_wcllb_i (llbctl_wcllb_i),
        .llbit_o        (llbit_o)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [68:0]   exp_dc_q[$];   // {we, addr, wdata, wstrb}
    logic [37:0]   exp_res_q[$];  // {ale, rd, data}
    bit            llbit_m = 1'b0;
    logic [DW-1:0] ref_mem [logic [DW-1:0]];
    logic [DW-1:0] cache_mem [logic [DW-1:0]];

    function automatic logic [DW-1:0] init_val(input logic [DW-1:0] a);
        return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [DW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [DW-1:0] cache_rd(input logic [DW-1:0] a);
        return cache_mem.exists(a) ? cache_mem[a] : init_val(a);
    endfunction

    // ---------------- data cache model ----------------
    int rdy_mode = 0;   // 0 always ready, 1 random, 2 never ready
    int lat_min = 1;
    int lat_max = 1;
    int pend_cnt = 0;
    logic [DW-1:0] pend_data = '0;
    int dc_valid_cnt = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            dc_rsp_valid_i = 1'b0;
            dc_rdata_i = '0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    dc_rsp_valid_i = 1'b1;
                    dc_rdata_i = pend_data;
                end
            end
            case (rdy_mode)
                0: dc_req_ready_i = 1'b1;
                1: dc_req_ready_i = 1'($urandom_range(0, 1));
                default: dc_req_ready_i = 1'b0;
            endcase
            @(negedge clk);
            if (dc_req_valid_o) dc_valid_cnt++;
            if (dc_req_valid_o && dc_req_ready_i) begin
                if (exp_dc_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL dc_unexpected got we=%0b addr=%0h, required no access", dc_we_o, dc_addr_o);
                end else begin
                    chk("dc_access", {dc_we_o, dc_addr_o, dc_wdata_o, dc_wstrb_o}, exp_dc_q.pop_front());
                end
                pend_data = dc_we_o ? '0 : cache_rd(dc_addr_o);
                if (dc_we_o) cache_mem[dc_addr_o] = dc_wdata_o;
                pend_cnt = $urandom_range(lat_min, lat_max);
            end
        end
    end

    // ---------------- writeback ready driver ----------------
    bit rr_rand = 1'b0;
    bit rr_val = 1'b1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            res_ready_i = rr_rand ? 1'($urandom_range(0, 1)) : rr_val;
        end
    end

    // ---------------- result monitor ----------------
    int res_cnt = 0;
    int res_cyc = 0;
    bit prev_hold = 1'b0;
    logic [37:0] prev_res = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else if (res_valid_o) begin
            if (prev_hold) chk("res_stable", {res_ale_o, res_rd_o, res_data_o}, prev_res);
            if (res_ready_i) begin
                res_cnt++;
                res_cyc = cyc;
                prev_hold = 1'b0;
                if (exp_res_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL res_unexpected got ale=%0b data=%0h, required no result", res_ale_o, res_data_o);
                end else begin
                    chk("res", {res_ale_o, res_rd_o, res_data_o}, exp_res_q.pop_front());
                end
            end else begin
                prev_hold = 1'b1;
                prev_res = {res_ale_o, res_rd_o, res_data_o};
            end
        end else begin
            prev_hold = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    int accept_cyc = 0;

    // mode: 0 normal, 1 drained (no result, LL does not set), 2 result dropped by flush, 3 no prediction
    task automatic predict(input bit is_sc, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [RW-1:0] rd, input int mode);
        if (mode == 3) return;
        if (addr[1:0] != 2'b00) begin
            if (mode == 0) exp_res_q.push_back({1'b1, rd, 32'h0});
        end else if (is_sc && !llbit_m) begin
            if (mode == 0) exp_res_q.push_back({1'b0, rd, 32'h0});
        end else if (!is_sc) begin
            exp_dc_q.push_back({1'b0, addr, 32'h0, 4'b0000});
            if (mode == 0) exp_res_q.push_back({1'b0, rd, ref_rd(addr)});
            if (mode != 1) llbit_m = 1'b1;
        end else begin
            exp_dc_q.push_back({1'b1, addr, wdata, 4'b1111});
            ref_mem[addr] = wdata;
            llbit_m = 1'b0;
            if (mode == 0) exp_res_q.push_back({1'b0, rd, 32'h1});
        end
    endtask

    // Returns one time unit after the edge following acceptance.
    task automatic send(input bit is_sc, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [RW-1:0] rd, input int mode);
        int n = 0;
        bit ok = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b1;
        req_is_sc_i = is_sc;
        req_addr_i = addr;
        req_wdata_i = wdata;
        req_rd_i = rd;
        forever begin
            @(negedge clk);
            if (req_ready_o) break;
            n++;
            if (n > 50) begin
                total++;
                bad++;
                $display("FAIL accept_timeout got no req_ready_o for %0d cycles, required ready", n);
                ok = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
        accept_cyc = cyc;
        if (ok) predict(is_sc, addr, wdata, rd, mode);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        req_is_sc_i = 1'b0;
        req_addr_i = '0;
        req_wdata_i = '0;
        req_rd_i = '0;
    endtask

    task automatic wait_quiet();
        int n = 0;
        forever begin
            @(negedge clk);
            if (req_ready_o && exp_res_q.size() == 0 && exp_dc_q.size() == 0 && pend_cnt == 0) break;
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL quiet_timeout got res_q=%0d dc_q=%0d pending, required 0", exp_res_q.size(), exp_dc_q.size());
                exp_res_q.delete();
                exp_dc_q.delete();
                break;
            end
        end
    endtask

    task automatic pulse_ctl(input bit ertn, input bit klo, input bit wcllb);
        @(posedge clk);
        #1;
        ertn_i = ertn;
        llbctl_klo_i = klo;
        llbctl_wcllb_i = wcllb;
        if ((ertn && !klo) || wcllb) llbit_m = 1'b0;
        @(posedge clk);
        #1;
        ertn_i = 1'b0;
        llbctl_klo_i = 1'b0;
        llbctl_wcllb_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int rc;
        int dcc;
        logic [DW-1:0] a;
        logic [DW-1:0] wd;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_res_valid", res_valid_o, 0);
        chk("rst_dc_valid", {dc_req_valid_o, dc_we_o, dc_wstrb_o}, 0);
        chk("rst_llbit", llbit_o, 0);
        step();
        rst = 1'b0;
        @(negedge clk);

        // LL with 0xDEADBEEF in the cache: result three cycles after acceptance
        cache_mem[32'h1000] = 32'hdeadbeef;
        ref_mem[32'h1000] = 32'hdeadbeef;
        send(1'b0, 32'h1000, 32'h0, 5'd3, 0);
        wait_quiet();
        chk("ll_latency", res_cyc - accept_cyc, 3);
        chk("ll_sets_llbit", llbit_o, 1);

        // SC after LL: one full-word store, result 1, LLbit cleared
        dcc = dc_valid_cnt;
        send(1'b1, 32'h1000, 32'h55, 5'd4, 0);
        wait_quiet();
        chk("sc_one_store", dc_valid_cnt - dcc, 1);
        chk("sc_clears_llbit", llbit_o, 0);

        // SC with LLbit clear: no cache access, result 0 the cycle after acceptance
        dcc = dc_valid_cnt;
        send(1'b1, 32'h1000, 32'h77, 5'd5, 0);
        wait_quiet();
        chk("sc_fail_no_access", dc_valid_cnt - dcc, 0);
        chk("sc_fail_latency", res_cyc - accept_cyc, 1);
        chk("sc_fail_mem_kept", cache_rd(32'h1000), 32'h55);

        // Misaligned LL with LLbit set: ALE, no access, LLbit untouched
        send(1'b0, 32'h1004, 32'h0, 5'd6, 0);
        wait_quiet();
        dcc = dc_valid_cnt;
        send(1'b0, 32'h1002, 32'h0, 5'd7, 0);
        wait_quiet();
        chk("ale_no_access", dc_valid_cnt - dcc, 0);
        chk("ale_llbit_kept", llbit_o, 1);

        // ERTN with KLO=1 keeps LLbit, with KLO=0 clears it
        pulse_ctl(1'b1, 1'b1, 1'b0);
        chk("ertn_klo1", llbit_o, 1);
        pulse_ctl(1'b1, 1'b0, 1'b0);
        chk("ertn_klo0", llbit_o, 0);

        // LL completion in the same cycle as WCLLB: clear wins, data still returned
        send(1'b0, 32'h1008, 32'h0, 5'd8, 0);
        step();
        llbctl_wcllb_i = 1'b1;
        step();
        llbctl_wcllb_i = 1'b0;
        llbit_m = 1'b0;
        wait_quiet();
        chk("ll_vs_wcllb", llbit_o, 0);

        // Flush while holding the result: valid drops, LLbit from the LL stands
        rr_val = 1'b0;
        send(1'b0, 32'h1004, 32'h0, 5'd9, 2);
        step();
        step();
        step();
        @(negedge clk);
        chk("resp_hold_valid", {res_valid_o, res_data_o}, {1'b1, ref_rd(32'h1004)});
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        @(negedge clk);
        chk("resp_flush_drop", res_valid_o, 0);
        chk("resp_flush_llbit", llbit_o, 1);
        rr_val = 1'b1;
        wait_quiet();

        // Flush in ISSUE with the cache stalled: back to IDLE, no access
        pulse_ctl(1'b0, 1'b0, 1'b1);
        rdy_mode = 2;
        @(negedge clk);
        dcc = dc_valid_cnt;
        send(1'b0, 32'h100c, 32'h0, 5'd10, 3);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        @(negedge clk);
        chk("issue_flush_idle", {req_ready_o, dc_req_valid_o}, 2'b10);
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        wait_quiet();
        chk("issue_flush_llbit", llbit_o, 0);

        // Flush in the handshake cycle: response drained, LL does not set LLbit
        lat_min = 2;
        lat_max = 2;
        rc = res_cnt;
        send(1'b0, 32'h100c, 32'h0, 5'd11, 1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        @(negedge clk);
        chk("issue_hs_flush_drain", req_ready_o, 0);
        wait_quiet();
        chk("issue_hs_flush_nores", res_cnt - rc, 0);
        chk("issue_hs_flush_llbit", llbit_o, 0);

        // Flush in WAIT, response three cycles after issue: discarded
        lat_min = 3;
        lat_max = 3;
        rc = res_cnt;
        send(1'b0, 32'h1000, 32'h0, 5'd12, 1);
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        @(negedge clk);
        chk("wait_flush_drain", req_ready_o, 0);
        wait_quiet();
        chk("wait_flush_nores", res_cnt - rc, 0);
        chk("wait_flush_llbit", llbit_o, 0);
        chk("wait_flush_ready", req_ready_o, 1);

        // Drained SC still clears LLbit and the store lands
        lat_min = 1;
        lat_max = 1;
        send(1'b0, 32'h100c, 32'h0, 5'd13, 0);
        wait_quiet();
        lat_min = 3;
        lat_max = 3;
        rc = res_cnt;
        wd = $urandom;
        send(1'b1, 32'h100c, wd, 5'd14, 1);
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        wait_quiet();
        chk("drain_sc_nores", res_cnt - rc, 0);
        chk("drain_sc_llbit", llbit_o, 0);
        lat_min = 1;
        lat_max = 1;
        send(1'b0, 32'h100c, 32'h0, 5'd15, 0);
        wait_quiet();

        // Reset with a response in flight: late response ignored
        lat_min = 3;
        lat_max = 3;
        rc = res_cnt;
        send(1'b0, 32'h1008, 32'h0, 5'd16, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        llbit_m = 1'b0;
        wait_quiet();
        repeat (2) @(negedge clk);
        chk("rst_inflight_nores", res_cnt - rc, 0);
        chk("rst_inflight_llbit", llbit_o, 0);
        chk("rst_inflight_ready", req_ready_o, 1);

        // Randomized traffic with backpressure and stalls
        rr_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            rdy_mode = $urandom_range(0, 1);
            lat_min = 1;
            lat_max = $urandom_range(1, 4);
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 1) pulse_ctl(1'b1, 1'($urandom_range(0, 1)), 1'b0);
                else pulse_ctl(1'b0, 1'b0, 1'b1);
            end
            a = 32'h1000 + 32'($urandom_range(0, 3) * 4);
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            send(1'($urandom_range(0, 1)), a, $urandom, 5'($urandom_range(0, 31)), 0);
            wait_quiet();
            chk("rand_llbit", llbit_o, llbit_m);
        end
        rr_rand = 1'b0;
        rr_val = 1'b1;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog got no completion, required finish before time limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
